// File: rtl/fm_ramp_if.sv
// fm_ramp_if -- configuration / status bundle for fm_ramp_gen.
//
// The master side drives the run enable and the cfg_* strobe group.
// The slave side (the ramp generator) returns the sweep state.
//
//   enable     run the sweep when high, freeze everything when low
//   cfg_base   sweep start increment
//   cfg_step   per-step delta, unsigned
//   cfg_last   last step index N
//   cfg_div    dwell per step is cfg_div+1 clocks
//   cfg_mode   0 = sawtooth, 1 = triangle
//   cfg_load   one-cycle strobe capturing all cfg_* fields
//   dout       current increment word
//   idx        current step index
//   dir        0 = counting up, 1 = counting down
//   step_strb  one-cycle pulse on every index change
//   update     one-cycle pulse when a sweep restarts at idx 0
//   pending    a captured config is waiting for the next sweep start
interface fm_ramp_if #(
    parameter int DSIZE   = 20,
    parameter int FMWIDTH = 8,
    parameter int DIVW    = 16
);
    logic               enable;
    logic [DSIZE-1:0]   cfg_base;
    logic [DSIZE-1:0]   cfg_step;
    logic [FMWIDTH-1:0] cfg_last;
    logic [DIVW-1:0]    cfg_div;
    logic               cfg_mode;
    logic               cfg_load;

    logic [DSIZE-1:0]   dout;
    logic [FMWIDTH-1:0] idx;
    logic               dir;
    logic               step_strb;
    logic               update;
    logic               pending;

    modport master (
        output enable, cfg_base, cfg_step, cfg_last, cfg_div, cfg_mode, cfg_load,
        input  dout, idx, dir, step_strb, update, pending
    );

    modport slave (
        input  enable, cfg_base, cfg_step, cfg_last, cfg_div, cfg_mode, cfg_load,
        output dout, idx, dir, step_strb, update, pending
    );
endinterface

// File: rtl/fm_ramp_gen.sv
// fm_ramp_gen -- stepped frequency-ramp generator.
//
// Produces an increment word that walks from base in steps of `step`,
// dwelling cfg_div+1 clocks on each step. The sweep restarts at idx 0
// after idx N (sawtooth) or after climbing to N and descending back
// (triangle). The word is accumulated with add/subtract only.
//
// Optional feature: define FM_RAMP_TRIANGLE_EN to build triangle mode.
// Without it cfg_mode is ignored, dir stays 0 and every sweep is a
// sawtooth.
//
// Ports:
//   inc    clock, all logic on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    fm_ramp_if.slave -- enable, cfg_* inputs, sweep status outputs
module fm_ramp_gen #(
    parameter int DSIZE   = 20,
    parameter int FMWIDTH = 8,
    parameter int DIVW    = 16
) (
    input  logic     inc,
    input  logic     rst_n,
    fm_ramp_if.slave bus
);

    // Active configuration (drives the sweep) and stored configuration
    // (captured while running, applied at the next sweep start).
    logic [DSIZE-1:0]   act_base, act_step;
    logic [FMWIDTH-1:0] act_last;
    logic [DIVW-1:0]    act_div;
    logic [DSIZE-1:0]   st_base, st_step;
    logic [FMWIDTH-1:0] st_last;
    logic [DIVW-1:0]    st_div;

    logic [DIVW-1:0]    div_cnt;
    logic [FMWIDTH-1:0] idx_q;
    logic               dir_q;
    logic [DSIZE-1:0]   dout_q;
    logic               strb_q;
    logic               upd_q;
    logic               pend_q;

    logic               tri_mode;

`ifdef FM_RAMP_TRIANGLE_EN
    logic               act_mode, st_mode;
    assign tri_mode = act_mode;
`else
    logic               unused_mode;
    assign unused_mode = bus.cfg_mode;
    assign tri_mode    = 1'b0;
`endif

    // Divider terminal count: this cycle advances the sweep.
    logic tc;
    assign tc = (div_cnt == act_div);

    // Next-step decision. `start` means the sweep returns to idx 0,
    // where dout reloads from base (possibly a freshly applied one).
    logic               start;
    logic [FMWIDTH-1:0] n_idx;
    logic               n_dir;
    logic [DSIZE-1:0]   n_dout;

    always_comb begin
        start  = 1'b0;
        n_idx  = idx_q;
        n_dir  = dir_q;
        n_dout = dout_q;
        if (tri_mode && dir_q) begin
            // Descending: the step that lands on 0 is a sweep start.
            if (idx_q == FMWIDTH'(1)) begin
                start = 1'b1;
            end else begin
                n_idx  = idx_q - FMWIDTH'(1);
                n_dout = dout_q - act_step;
            end
        end else if (idx_q == act_last) begin
            if (!tri_mode || act_last <= FMWIDTH'(1)) begin
                // Sawtooth wrap, N=0, or triangle with N=1 (next is 0).
                start = 1'b1;
            end else begin
                // Triangle peak: turn around without repeating N.
                n_idx  = idx_q - FMWIDTH'(1);
                n_dir  = 1'b1;
                n_dout = dout_q - act_step;
            end
        end else begin
            n_idx  = idx_q + FMWIDTH'(1);
            n_dout = dout_q + act_step;
        end
    end

    always_ff @(posedge inc or negedge rst_n) begin
        if (!rst_n) begin
            act_base <= '0;
            act_step <= '0;
            act_last <= '0;
            act_div  <= '0;
            st_base  <= '0;
            st_step  <= '0;
            st_last  <= '0;
            st_div   <= '0;
`ifdef FM_RAMP_TRIANGLE_EN
            act_mode <= 1'b0;
            st_mode  <= 1'b0;
`endif
            div_cnt  <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            dout_q   <= '0;
            strb_q   <= 1'b0;
            upd_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            strb_q <= 1'b0;
            upd_q  <= 1'b0;
            if (bus.cfg_load && !bus.enable) begin
                // Idle load: take effect at once and restart the sweep.
                act_base <= bus.cfg_base;
                act_step <= bus.cfg_step;
                act_last <= bus.cfg_last;
                act_div  <= bus.cfg_div;
`ifdef FM_RAMP_TRIANGLE_EN
                act_mode <= bus.cfg_mode;
`endif
                div_cnt  <= '0;
                idx_q    <= '0;
                dir_q    <= 1'b0;
                dout_q   <= bus.cfg_base;
                pend_q   <= 1'b0;
            end else if (bus.enable) begin
                if (bus.cfg_load) begin
                    // Running load: park it; a later load overwrites.
                    st_base <= bus.cfg_base;
                    st_step <= bus.cfg_step;
                    st_last <= bus.cfg_last;
                    st_div  <= bus.cfg_div;
`ifdef FM_RAMP_TRIANGLE_EN
                    st_mode <= bus.cfg_mode;
`endif
                    pend_q  <= 1'b1;
                end
                if (tc) begin
                    div_cnt <= '0;
                    if (start) begin
                        idx_q  <= '0;
                        dir_q  <= 1'b0;
                        upd_q  <= 1'b1;
                        strb_q <= (idx_q != '0);
                        pend_q <= 1'b0;
                        // A strobe coinciding with the start wins over
                        // anything parked earlier.
                        if (bus.cfg_load) begin
                            act_base <= bus.cfg_base;
                            act_step <= bus.cfg_step;
                            act_last <= bus.cfg_last;
                            act_div  <= bus.cfg_div;
`ifdef FM_RAMP_TRIANGLE_EN
                            act_mode <= bus.cfg_mode;
`endif
                            dout_q   <= bus.cfg_base;
                        end else if (pend_q) begin
                            act_base <= st_base;
                            act_step <= st_step;
                            act_last <= st_last;
                            act_div  <= st_div;
`ifdef FM_RAMP_TRIANGLE_EN
                            act_mode <= st_mode;
`endif
                            dout_q   <= st_base;
                        end else begin
                            dout_q   <= act_base;
                        end
                    end else begin
                        idx_q  <= n_idx;
                        dir_q  <= n_dir;
                        dout_q <= n_dout;
                        strb_q <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + DIVW'(1);
                end
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.idx       = idx_q;
    assign bus.dir       = dir_q;
    assign bus.step_strb = strb_q;
    assign bus.update    = upd_q;
    assign bus.pending   = pend_q;

endmodule

// File: tb/tb_fm_ramp_gen.sv
// tb_fm_ramp_gen -- directed and randomized check of fm_ramp_gen against a
// sweep-phase reference model (dout = base + idx*step, idx from phase).
module tb_fm_ramp_gen;
    localparam int DSIZE   = 20;
    localparam int FMWIDTH = 8;
    localparam int DIVW    = 16;

    logic inc   = 1'b0;
    logic rst_n = 1'b0;
    always #5 inc = ~inc;

    fm_ramp_if #(.DSIZE(DSIZE), .FMWIDTH(FMWIDTH), .DIVW(DIVW)) bus ();

    fm_ramp_gen #(.DSIZE(DSIZE), .FMWIDTH(FMWIDTH), .DIVW(DIVW)) dut (
        .inc   (inc),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DSIZE-1:0] m_base, m_step, s_base, s_step;
    int               m_last, m_div, s_last, s_div;
    bit               m_mode, s_mode, m_pend;
    int               m_cnt, m_p;
    bit               e_strb, e_upd;

    function automatic bit m_tri();
`ifdef FM_RAMP_TRIANGLE_EN
        return m_mode;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_period();
        if (m_tri() && m_last > 0) return 2 * m_last;
        return m_last + 1;
    endfunction

    function automatic int m_idx();
        return (m_p <= m_last) ? m_p : 2 * m_last - m_p;
    endfunction

    function automatic logic [DSIZE-1:0] m_dout();
        logic [63:0] t;
        t = 64'(m_base) + 64'(m_idx()) * 64'(m_step);
        return t[DSIZE-1:0];
    endfunction

    task automatic model_reset();
        m_base = '0; m_step = '0; m_last = 0; m_div = 0; m_mode = 0;
        s_base = '0; s_step = '0; s_last = 0; s_div = 0; s_mode = 0;
        m_pend = 0; m_cnt = 0; m_p = 0; e_strb = 0; e_upd = 0;
    endtask

    task automatic apply_inputs();
        m_base = bus.cfg_base; m_step = bus.cfg_step;
        m_last = int'(bus.cfg_last); m_div = int'(bus.cfg_div); m_mode = bus.cfg_mode;
    endtask

    task automatic model_step();
        int old_idx;
        old_idx = m_idx();
        e_strb  = 0;
        e_upd   = 0;
        if (bus.cfg_load && !bus.enable) begin
            apply_inputs();
            m_p = 0; m_cnt = 0; m_pend = 0;
        end else if (bus.enable) begin
            if (bus.cfg_load) begin
                s_base = bus.cfg_base; s_step = bus.cfg_step;
                s_last = int'(bus.cfg_last); s_div = int'(bus.cfg_div); s_mode = bus.cfg_mode;
                m_pend = 1;
            end
            if (m_cnt == m_div) begin
                m_cnt = 0;
                m_p   = (m_p + 1) % m_period();
                if (m_p == 0) begin
                    e_upd = 1;
                    if (m_pend) begin
                        m_base = s_base; m_step = s_step; m_last = s_last;
                        m_div = s_div; m_mode = s_mode;
                    end
                    m_pend = 0;
                end
                e_strb = (m_idx() != old_idx);
            end else begin
                m_cnt++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_all(input string tag);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(m_dout()));
        chk({tag, ".idx"},  32'(bus.idx),  32'(m_idx()));
        chk({tag, ".dir"},  32'(bus.dir),  32'(m_tri() && (m_p > m_last)));
        chk({tag, ".strb"}, 32'(bus.step_strb), 32'(e_strb));
        chk({tag, ".upd"},  32'(bus.update),    32'(e_upd));
        chk({tag, ".pend"}, 32'(bus.pending),   32'(m_pend));
    endtask

    task automatic tick(input string tag);
        @(posedge inc);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [DSIZE-1:0] b, input logic [DSIZE-1:0] s,
                           input int n, input int d, input bit md);
        bus.cfg_base = b;
        bus.cfg_step = s;
        bus.cfg_last = FMWIDTH'(n);
        bus.cfg_div  = DIVW'(d);
        bus.cfg_mode = md;
        bus.cfg_load = 1'b1;
        tick(tag);
        bus.cfg_load = 1'b0;
    endtask

    task automatic wait_idx(input string tag, input int target);
        bit found;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (int'(bus.idx) == target) found = 1;
            else tick(tag);
        end
        chk({tag, ".reach"}, 32'(found), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".dout"}, 32'(bus.dout), 32'd0);
        chk({tag, ".idx"},  32'(bus.idx), 32'd0);
        chk({tag, ".dir"},  32'(bus.dir), 32'd0);
        chk({tag, ".strb"}, 32'(bus.step_strb), 32'd0);
        chk({tag, ".upd"},  32'(bus.update), 32'd0);
        chk({tag, ".pend"}, 32'(bus.pending), 32'd0);
    endtask

    initial begin
        logic [DSIZE-1:0] saw_seq [4];
        saw_seq = '{20'd2796, 20'd3331, 20'd3866, 20'd4401};

        bus.enable = 1'b0; bus.cfg_base = '0; bus.cfg_step = '0; bus.cfg_last = '0;
        bus.cfg_div = '0; bus.cfg_mode = 1'b0; bus.cfg_load = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge inc);
        #1 check_zero("reset");
        @(negedge inc);
        rst_n = 1'b1;

        // Power-on defaults: N=0, div=0 -> update every cycle, dout=0
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("por");
            chk("por.upd_const", 32'(bus.update), 32'd1);
        end

        // Sawtooth: base=2796 step=535 N=3 div=1
        bus.enable = 1'b0;
        do_load("sawload", 20'd2796, 20'd535, 3, 1, 1'b0);
        chk("saw.first", 32'(bus.dout), 32'd2796);
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick("saw");
            chk("saw.tbl", 32'(bus.dout), 32'(saw_seq[((i + 1) / 2) % 4]));
        end

        // Deferred load at idx=2
        wait_idx("defer.w2", 2);
        do_load("defer.ld", 20'd5000, 20'd535, 3, 1, 1'b0);
        chk("defer.pend", 32'(bus.pending), 32'd1);
        wait_idx("defer.w0", 0);
        chk("defer.dout", 32'(bus.dout), 32'd5000);
        chk("defer.pclr", 32'(bus.pending), 32'd0);

        // Freeze at idx=2 for 10 cycles, then resume
        wait_idx("frz.w2", 2);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) tick("frz.hold");
        chk("frz.idx", 32'(bus.idx), 32'd2);
        bus.enable = 1'b1;
        for (int i = 0; i < 8; i++) tick("frz.run");

        // Wrap: 0xFFFF0 + 0x10 wraps to 0
        bus.enable = 1'b0;
        do_load("wrapld", 20'hFFFF0, 20'h10, 1, 0, 1'b0);
        bus.enable = 1'b1;
        tick("wrap");
        chk("wrap.zero", 32'(bus.dout), 32'h00000);
        tick("wrap");
        chk("wrap.back", 32'(bus.dout), 32'hFFFF0);

`ifdef FM_RAMP_TRIANGLE_EN
        // Triangle: 100,110,120,110,100,...
        bus.enable = 1'b0;
        do_load("trild", 20'd100, 20'd10, 2, 0, 1'b1);
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) tick("tri");
`endif

        // Randomized enable / load traffic
        for (int i = 0; i < 500; i++) begin
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 14) == 0)
                do_load("rnd.ld", DSIZE'($urandom), DSIZE'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                        bit'($urandom_range(0, 1)));
            else
                tick("rnd");
        end

        // Mid-cycle asynchronous reset
        bus.enable = 1'b1;
        do_load("arst.ld", 20'd777, 20'd3, 4, 2, 1'b0);
        repeat (5) tick("arst.run");
        @(posedge inc);
        model_step();
        #3 rst_n = 1'b0;
        #1 check_zero("arst");
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("arst.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/fm_ramp_gen.md
FM_RAMP_GEN -- requirements
Module: fm_ramp_gen

Interface
REQ-001 Parameter DSIZE, default 20, SHALL set the width of the increment word (dout, cfg_base, cfg_step).
REQ-002 Parameter FMWIDTH, default 8, SHALL set the step-index width; sweeps SHALL be up to 2**FMWIDTH steps.
REQ-003 Parameter DIVW, default 16, SHALL set the width of the divider count.
REQ-004 inc  in  1  SHALL be the single clock; all logic on posedge inc.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 enable  in  1  SHALL run the sweep when high and hold all state when low.
REQ-007 cfg_base  in  DSIZE  SHALL be the sweep start increment.
REQ-008 cfg_step  in  DSIZE  SHALL be the per-step delta, unsigned.
REQ-009 cfg_last  in  FMWIDTH  SHALL be the last step index N.
REQ-010 cfg_div  in  DIVW  SHALL give each step a dwell of cfg_div+1 inc cycles.
REQ-011 cfg_mode  in  1  SHALL select the sweep shape: 0 = sawtooth, 1 = triangle.
REQ-012 cfg_load  in  1  SHALL be a one-cycle strobe that captures all cfg_* inputs.
REQ-013 dout  out  DSIZE  SHALL be the current increment word, registered.
REQ-014 idx  out  FMWIDTH  SHALL be the current step index, registered.
REQ-015 dir  out  1  SHALL be the current direction: 0 = up, 1 = down.
REQ-016 step_strb  out  1  SHALL pulse for one cycle on every index change.
REQ-017 update  out  1  SHALL pulse for one cycle when a new sweep starts at idx 0.
REQ-018 pending  out  1  SHALL be high while a captured config waits to be applied.

Function
REQ-019 The divider SHALL count 0..cfg_div while enable is high; reaching terminal count SHALL restart it at 0 and advance one step in the same cycle.
REQ-020 dout SHALL equal base + idx*step modulo 2**DSIZE, computed by incremental add/subtract of step; no multiplier.
REQ-021 Sawtooth: idx SHALL run 0,1,..,N then 0; the wrap SHALL load dout=base and raise update.
REQ-022 Triangle: idx SHALL run 0..N up, then N-1..1 down, then 0; dir SHALL toggle at N and at 0; endpoints SHALL not repeat; arriving at 0 SHALL raise update.
REQ-023 N=0 SHALL hold dout=base, and update SHALL pulse at every divider terminal count.
REQ-024 step_strb and update SHALL be asserted in the cycle after the terminal count, together with the new dout and idx.
REQ-025 cfg_load with enable low SHALL apply immediately: next cycle idx=0, dir=0, divider=0, dout=cfg_base, pending=0.
REQ-026 cfg_load with enable high SHALL store the config and set pending; the config SHALL apply at the next sweep start (idx back to 0), which clears pending.
REQ-027 A cfg_load in the same cycle as a sweep start SHALL apply the strobed values at that start.
REQ-028 A second cfg_load while pending SHALL overwrite the stored config.
REQ-029 enable deasserted mid-sweep SHALL freeze the divider, idx, dir and dout; reasserting SHALL resume with no lost or extra cycle.

Reset
REQ-030 rst_n low SHALL asynchronously clear the active config, the stored config, divider, idx, dir, dout, step_strb, update and pending to 0.
REQ-031 After reset release with no cfg_load, an enabled block SHALL output dout=0 and pulse update every cycle (N=0, div=0).

Configuration
REQ-032 With macro FM_RAMP_TRIANGLE_EN defined, triangle mode SHALL be implemented per REQ-022.
REQ-033 Without FM_RAMP_TRIANGLE_EN, cfg_mode SHALL be ignored, dir SHALL be tied 0, and all sweeps SHALL be sawtooth.

Verification
REQ-034 Sawtooth test: enable low; cfg_load with base=2796, step=535, N=3, div=1, mode=0; then enable high. dout SHALL be 2796,3331,3866,4401,2796, each held 2 cycles, with update at each return to 2796.
REQ-035 Triangle test (macro on): base=100, step=10, N=2, div=0, mode=1. dout SHALL be 100,110,120,110,100,110…; dir SHALL be 1 exactly while dout=110 after 120; update SHALL pulse whenever dout returns to 100.
REQ-036 Wrap test: base=0xFFFF0, step=0x10, N=1, div=0. dout SHALL be 0xFFFF0, 0x00000, 0xFFFF0.
REQ-037 Deferred-load test: during the sawtooth test at idx=2, cfg_load base=5000. pending SHALL be 1 until the next idx=0, where dout SHALL be 5000 and pending SHALL be 0.
REQ-038 Freeze and reset test: drop enable at idx=2 for 10 cycles. idx and dout SHALL stay frozen, and the remaining dwell SHALL resume unchanged. Then pulse rst_n low mid-cycle: all outputs SHALL be 0 immediately.
